// File: rtl/dma_ctrl.sv
// -----------------------------------------------------------------------------
// dma_ctrl
//
// Single-channel byte DMA engine for a Z80 system. It moves bytes between
// memory and an I/O port. The CPU programs it through five byte registers.
// It requests the bus with BUSREQ/BUSACK and then drives the master bus itself.
//
// Register map (cpu_addr_i):
//   0 MEM_LO   memory address, low byte (working value, increments per byte)
//   1 MEM_HI   memory address, high byte
//   2 COUNT    bytes remaining (0 means 256)
//   3 PORT     I/O port (optionally increments per byte)
//   4 CTRL     write: [0] start [1] dir [2] port_inc [3] abort [4] irq_en
//      STATUS  read : {busy, done, 0, irq_en, 0, port_inc, dir, 0}
//
// Each byte takes 5 cycles: RD (2) + WR (2) + NEXT (1).
// dir = 0 : read memory, write I/O.
// dir = 1 : read I/O,    write memory.
//
// Optional feature (compile-time macro DMA_IRQ_EN):
//   defined   : the irq_en control bit and the level interrupt irq_o are live.
//   undefined : irq_o is tied low and irq_en reads as 0. Software can still
//               poll the done bit.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   cs_i, cpu_wr_n_i         register select, CPU write strobe (active-low)
//   cpu_addr_i, cpu_data_i   register index, write data
//   cpu_data_o               read data (0x00 when cs_i is low)
//   busreq_n_o, busack_n_i   Z80 bus request / acknowledge (active-low)
//   bus_en_o                 high while this block owns the bus (master mux)
//   m_addr_o, m_data_o       master address / write data (0 when not owner)
//   m_data_i                 master read data
//   m_mreq_n_o, m_ioreq_n_o  master memory / I/O request strobes (active-low)
//   m_rd_n_o, m_wr_n_o       master read / write strobes (active-low)
//   irq_o                    transfer-complete interrupt, level, active-high
//
// State table:
//   state  | meaning
//   IDLE   | not busy; registers writable; waits for a start write
//   REQ    | busreq asserted; waits for busack (abort goes straight to REL)
//   RD     | 2-cycle read of the source side; data captured on the final edge
//   WR     | 2-cycle write of the captured byte to the destination side
//   NEXT   | 1 cycle, strobes idle; advances COUNT/MEM/PORT
//   REL    | bus released, busreq high; waits for busack to drop
// -----------------------------------------------------------------------------
module dma_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cs_i,
    input  logic        cpu_wr_n_i,
    input  logic [2:0]  cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        busreq_n_o,
    input  logic        busack_n_i,
    output logic        bus_en_o,
    output logic [15:0] m_addr_o,
    output logic [7:0]  m_data_o,
    input  logic [7:0]  m_data_i,
    output logic        m_mreq_n_o,
    output logic        m_ioreq_n_o,
    output logic        m_rd_n_o,
    output logic        m_wr_n_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_NEXT = 3'd4,
        S_REL  = 3'd5
    } state_t;

    localparam logic [2:0] A_MEM_LO = 3'd0;
    localparam logic [2:0] A_MEM_HI = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_PORT   = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    // RD and WR phase timer: loaded to 1 on entry, terminal count at 0.
    localparam logic PH_LOAD = 1'b1;

    state_t      state_q, state_d;
    logic        tmr_q;
    logic [15:0] mem_q;
    logic [7:0]  count_q;
    logic [7:0]  port_q;
    logic [7:0]  data_q;
    logic        dir_q;
    logic        port_inc_q;
    logic        done_q;
    logic        abort_q;
    logic        irq_en;

    logic        busy;
    logic        xfer_active;
    logic        reg_wr;
    logic        ctrl_wr;
    logic        start_wr;
    logic        abort_wr;
    logic        abort_req;
    logic        tmr_done;
    logic        last_byte;
    logic        enter_idle;
    logic [7:0]  status;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    assign busy        = (state_q != S_IDLE);
    assign xfer_active = (state_q == S_REQ) || (state_q == S_RD) ||
                         (state_q == S_WR)  || (state_q == S_NEXT);
    assign reg_wr      = cs_i & ~cpu_wr_n_i;
    assign ctrl_wr     = reg_wr && (cpu_addr_i == A_CTRL);
    assign start_wr    = ctrl_wr && cpu_data_i[0] && !busy;
    assign abort_wr    = ctrl_wr && cpu_data_i[3] && busy;
    // The abort written this cycle counts as well as one latched earlier,
    // so an abort that lands on the edge leaving NEXT still stops the run.
    assign abort_req   = abort_q | abort_wr;
    assign tmr_done    = (tmr_q == 1'b0);
    // COUNT==0 encodes 256, so only a value of 1 marks the final byte.
    assign last_byte   = (count_q == 8'd1);
    assign enter_idle  = (state_q == S_REL) && (state_d == S_IDLE);
    assign status      = {busy, done_q, 1'b0, irq_en, 1'b0, port_inc_q, dir_q, 1'b0};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (abort_req) begin
                    state_d = S_REL;
                end else if (!busack_n_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (tmr_done) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (tmr_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort_req || last_byte) begin
                    state_d = S_REL;
                end else begin
                    state_d = S_RD;
                end
            end
            S_REL: begin
                if (busack_n_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (purely from state, so reset forces them immediately)
    // -------------------------------------------------------------------------
    always_comb begin
        busreq_n_o  = 1'b1;
        bus_en_o    = 1'b0;
        m_addr_o    = 16'h0000;
        m_data_o    = 8'h00;
        m_mreq_n_o  = 1'b1;
        m_ioreq_n_o = 1'b1;
        m_rd_n_o    = 1'b1;
        m_wr_n_o    = 1'b1;
        case (state_q)
            S_REQ: begin
                busreq_n_o = 1'b0;
            end
            S_RD: begin
                busreq_n_o = 1'b0;
                bus_en_o   = 1'b1;
                m_data_o   = data_q;
                m_rd_n_o   = 1'b0;
                if (dir_q) begin
                    m_addr_o    = {8'h00, port_q};
                    m_ioreq_n_o = 1'b0;
                end else begin
                    m_addr_o   = mem_q;
                    m_mreq_n_o = 1'b0;
                end
            end
            S_WR: begin
                busreq_n_o = 1'b0;
                bus_en_o   = 1'b1;
                m_data_o   = data_q;
                m_wr_n_o   = 1'b0;
                if (dir_q) begin
                    m_addr_o   = mem_q;
                    m_mreq_n_o = 1'b0;
                end else begin
                    m_addr_o    = {8'h00, port_q};
                    m_ioreq_n_o = 1'b0;
                end
            end
            S_NEXT: begin
                busreq_n_o = 1'b0;
                bus_en_o   = 1'b1;
                m_data_o   = data_q;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Phase timer for the two-cycle RD and WR states
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr_q <= 1'b0;
        end else if ((state_d != state_q) && ((state_d == S_RD) || (state_d == S_WR))) begin
            tmr_q <= PH_LOAD;
        end else if (!tmr_done) begin
            tmr_q <= tmr_q - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Working registers, captured data, done flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q      <= 16'h0000;
            count_q    <= 8'h00;
            port_q     <= 8'h00;
            data_q     <= 8'h00;
            dir_q      <= 1'b0;
            port_inc_q <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (reg_wr && !busy) begin
                case (cpu_addr_i)
                    A_MEM_LO: mem_q[7:0]  <= cpu_data_i;
                    A_MEM_HI: mem_q[15:8] <= cpu_data_i;
                    A_COUNT:  count_q     <= cpu_data_i;
                    A_PORT:   port_q      <= cpu_data_i;
                    A_CTRL: begin
                        dir_q      <= cpu_data_i[1];
                        port_inc_q <= cpu_data_i[2];
                    end
                    default: begin
                    end
                endcase
            end

            if ((state_q == S_RD) && tmr_done) begin
                data_q <= m_data_i;
            end

            if (state_q == S_NEXT) begin
                count_q <= count_q - 8'd1;
                mem_q   <= mem_q + 16'd1;
                if (port_inc_q) begin
                    port_q <= port_q + 8'd1;
                end
            end

            // Abort is held only while a transfer is in flight; REL and IDLE
            // clear it so it cannot leak into the next run.
            abort_q <= xfer_active && abort_req;

            if (ctrl_wr) begin
                done_q <= 1'b0;
            end
            if (enter_idle) begin
                done_q <= 1'b1;
            end
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr && !busy) begin
                irq_en_q <= cpu_data_i[4];
            end
            if (ctrl_wr) begin
                irq_q <= 1'b0;
            end
            if (enter_idle) begin
                irq_q <= irq_en_q;
            end
        end
    end

    assign irq_en = irq_en_q;
    assign irq_o  = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // CPU read mux
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_data_o = 8'h00;
        if (cs_i) begin
            case (cpu_addr_i)
                A_MEM_LO: cpu_data_o = mem_q[7:0];
                A_MEM_HI: cpu_data_o = mem_q[15:8];
                A_COUNT:  cpu_data_o = count_q;
                A_PORT:   cpu_data_o = port_q;
                A_CTRL:   cpu_data_o = status;
                default:  cpu_data_o = 8'h00;
            endcase
        end
    end

endmodule
